calc_bcd_display: RTL and testbench

Downstream output stage for the `tt_um_calculator` datapath. It accepts each 8-bit unsigned calculator result through a valid/ready handshake and converts it to three BCD digits with an iterative double-dabble engine, one bit per cycle. It then drives a time-multiplexed, active-high 7-segment display with leading-zero blanking. Its outputs map onto `uo_out` (segments) and `uio_out` (digit selects) in the top level.

---
 rtl/calc_bcd_display.sv | 163 ++++++++++++++++
 tb/tb_calc_bcd_display.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_bcd_display.sv
// Accepts 8-bit calculator results, converts them to BCD with an iterative
// double-dabble engine and drives a multiplexed 7-segment display with blanking.
module calc_bcd_display #(
    parameter int unsigned SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] result,
    input  logic       result_valid,
    output logic       result_ready,
    output logic       busy,
    output logic [6:0] seg,
    output logic [2:0] digit_sel
);

    localparam int unsigned SCAN_W = 16;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // state  | meaning
    // S_IDLE | waiting for a result, ready follows ena
    // S_CONV | double-dabble running, one bit per enabled cycle
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [11:0]        scratch_q, scratch_d;
    logic [11:0]        disp_q, disp_d;
    logic [2:0]         step_q, step_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;

    logic [11:0]        scratch_adj;
    logic [19:0]        dd_shifted;
    logic [3:0]         digit_val;
    logic               digit_blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 3; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        // The top bit of the adjusted scratch is always 0 for 8-bit inputs.
        dd_shifted = {scratch_adj[10:0], shift_q, 1'b0};
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        scratch_d    = scratch_q;
        step_d       = step_q;
        disp_d       = disp_q;
        result_ready = 1'b0;
        busy         = 1'b0;

        case (state_q)
            S_IDLE: begin
                result_ready = ena;
                if (ena && result_valid) begin
                    shift_d   = result;
                    scratch_d = 12'h000;
                    step_d    = 3'd0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                busy = 1'b1;
                if (ena) begin
                    scratch_d = dd_shifted[19:8];
                    shift_d   = dd_shifted[7:0];
                    step_d    = step_q + 3'd1;
                    if (step_q == 3'd7) begin
                        state_d = S_IDLE;
                        disp_d  = dd_shifted[19:8];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        digit_idx_d = digit_idx_q;
        if (ena) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d  = '0;
                digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
            end else begin
                scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            end
        end
    end

    // Decoded purely from registers so digit_sel and seg switch together.
    always_comb begin
        digit_sel   = 3'b001;
        digit_val   = disp_q[3:0];
        digit_blank = 1'b0;
        case (digit_idx_q)
            2'd1: begin
                digit_sel   = 3'b010;
                digit_val   = disp_q[7:4];
                digit_blank = (disp_q[11:4] == 8'h00);
            end
            2'd2: begin
                digit_sel   = 3'b100;
                digit_val   = disp_q[11:8];
                digit_blank = (disp_q[11:8] == 4'h0);
            end
            default: begin
                digit_sel   = 3'b001;
                digit_val   = disp_q[3:0];
                digit_blank = 1'b0;
            end
        endcase
        seg = digit_blank ? 7'h00 : seg7(digit_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= 8'h00;
            scratch_q   <= 12'h000;
            step_q      <= 3'd0;
            disp_q      <= 12'h000;
            scan_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            step_q      <= step_d;
            disp_q      <= disp_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
        end
    end

endmodule

// File: tb/tb_calc_bcd_display.sv
// Directed bench for calc_bcd_display with a short scan period.
module tb_calc_bcd_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
    logic [6:0] seg;
    logic [2:0] digit_sel;

    int n_checks = 0;
    int n_errors = 0;

    calc_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .seg          (seg),
        .digit_sel    (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected segments for a decimal value on the given digit position.
    function automatic logic [6:0] exp_seg(input int val, input logic [2:0] sel);
        int u, t, h;
        u = val % 10;
        t = (val / 10) % 10;
        h = val / 100;
        case (sel)
            3'b001:  return seg_of(u);
            3'b010:  return (h == 0 && t == 0) ? 7'h00 : seg_of(t);
            3'b100:  return (h == 0) ? 7'h00 : seg_of(h);
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check_digits(input string tag, input logic [6:0] u, input logic [6:0] t,
                                input logic [6:0] h);
        logic [2:0] tgt;
        logic [6:0] exp;
        int n;
        for (int i = 0; i < 3; i++) begin
            tgt = 3'b001 << i;
            exp = (i == 0) ? u : (i == 1) ? t : h;
            n = 0;
            while (digit_sel !== tgt && n < 4 * SCAN_DIV) begin
                step();
                n++;
            end
            chk({tag, "_sel"}, digit_sel, tgt);
            chk({tag, "_seg"}, seg, exp);
        end
    endtask

    // Presents v until accepted; returns sampled just after the transfer edge.
    task automatic send(input logic [7:0] v);
        int n;
        result       = v;
        result_valid = 1'b1;
        n = 0;
        while (!result_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", result_ready, 1'b1);
        step();
        result_valid = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic measure_dwell(output int d);
        logic [2:0] s0;
        int n;
        s0 = digit_sel;
        n = 0;
        while (digit_sel === s0 && n < 4 * SCAN_DIV) begin
            step();
            n++;
        end
        s0 = digit_sel;
        d = 0;
        while (digit_sel === s0 && d < 60) begin
            step();
            d++;
        end
    endtask

    initial begin
        int n;
        int dwell;
        int busy_cnt;
        logic [2:0] sel0;
        bit changed;

        rst_n        = 1'b0;
        ena          = 1'b1;
        result       = 8'h00;
        result_valid = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_sel", digit_sel, 3'b001);
        chk("rst_seg", seg, 7'h3F);
        chk("rst_ready", result_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rel_sel", digit_sel, 3'b001);
        chk("rel_seg", seg, 7'h3F);
        chk("rel_ready", result_ready, 1'b1);

        // Full scale: 255
        send(8'd255);
        chk("ff_busy", busy, 1'b1);
        chk("ff_ready_low", result_ready, 1'b0);
        busy_len(n);
        chk("ff_busy_len", n, 8);
        chk("ff_ready_back", result_ready, 1'b1);
        check_digits("ff", 7'h6D, 7'h6D, 7'h5B);
        measure_dwell(dwell);
        chk("ff_dwell", dwell, SCAN_DIV);
        measure_dwell(dwell);
        chk("ff_dwell2", dwell, SCAN_DIV);

        // Blanking
        send(8'd7);
        busy_len(n);
        chk("b7_len", n, 8);
        check_digits("b7", 7'h07, 7'h00, 7'h00);
        send(8'd100);
        busy_len(n);
        check_digits("b100", 7'h3F, 7'h3F, 7'h06);
        send(8'd0);
        busy_len(n);
        check_digits("b0", 7'h3F, 7'h00, 7'h00);

        // Valid held while busy: 42 then 99
        result       = 8'd42;
        result_valid = 1'b1;
        chk("vb_ready0", result_ready, 1'b1);
        step();
        result = 8'd99;
        chk("vb_busy", busy, 1'b1);
        chk("vb_not_ready", result_ready, 1'b0);
        n = 0;
        while (!result_ready && n < 40) begin
            step();
            n++;
        end
        chk("vb_42_len", n, 8);
        chk("vb_42_shown", seg, exp_seg(42, digit_sel));
        step();
        result_valid = 1'b0;
        chk("vb_99_busy", busy, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            chk("vb_42_hold", seg, exp_seg(42, digit_sel));
            step();
            n++;
        end
        chk("vb_99_len", n, 8);
        check_digits("vb99", 7'h6F, 7'h6F, 7'h00);

        // Reset mid-conversion
        send(8'd200);
        repeat (4) step();
        chk("mr_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_sel", digit_sel, 3'b001);
        chk("mr_seg", seg, 7'h3F);
        chk("mr_ready", result_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        check_digits("mr0", 7'h3F, 7'h00, 7'h00);
        send(8'd13);
        busy_len(n);
        chk("mr13_len", n, 8);
        check_digits("mr13", 7'h4F, 7'h06, 7'h00);

        // ena gating during conversion of 128 and during a digit dwell
        sel0 = digit_sel;
        n = 0;
        while (digit_sel === sel0 && n < 4 * SCAN_DIV) begin
            step();
            n++;
        end
        sel0         = digit_sel;
        dwell        = 1;
        changed      = 1'b0;
        busy_cnt     = 0;
        result       = 8'd128;
        result_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (busy) busy_cnt++;
            if (!changed && digit_sel === sel0) dwell++;
            else changed = 1'b1;
            if (k == 1) result_valid = 1'b0;
            if (k == 2) ena = 1'b0;
            if (k == 4) chk("eg_hold_busy", busy, 1'b1);
            if (k == 4) chk("eg_hold_ready", result_ready, 1'b0);
            if (k == 7) ena = 1'b1;
        end
        chk("eg_busy_len", busy_cnt, 13);
        chk("eg_dwell", dwell, SCAN_DIV + 5);
        check_digits("eg128", 7'h7F, 7'h5B, 7'h06);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
